// File: rtl/demux1to2_stream.sv
// demux1to2_stream: steers one valid/ready stream to one of two outputs
// by sel, with a small FIFO and an accepted-beat counter per output.

module demux1to2_fifo #(
  parameter int N     = 4,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [N-1:0] wdata,
  input  logic         pop,
  output logic         full,
  output logic         valid,
  output logic [N-1:0] rdata
);
  localparam int AW = $clog2(DEPTH);

  logic [N-1:0] mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW:0]   occ;
  logic          pop_en;

  assign full   = (occ == (AW+1)'(DEPTH));
  assign valid  = (occ != '0);
  assign pop_en = pop && valid;
  // Head is masked while empty so the port reads 0 out of reset.
  assign rdata  = valid ? mem[rptr] : '0;

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      occ  <= '0;
    end else begin
      if (push)   wptr <= wptr + 1'b1;
      if (pop_en) rptr <= rptr + 1'b1;
      unique case ({push, pop_en})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end
endmodule

module demux1to2_stream #(
  parameter int N     = 4,
  parameter int DEPTH = 2,
  parameter int CW    = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          sel,
  input  logic [N-1:0]  in_data,
  output logic          a_valid,
  input  logic          a_ready,
  output logic [N-1:0]  a_data,
  output logic          b_valid,
  input  logic          b_ready,
  output logic [N-1:0]  b_data,
  output logic [CW-1:0] a_count,
  output logic [CW-1:0] b_count
);
  logic full_a;
  logic full_b;
  logic accept;
  logic push_a;
  logic push_b;

  // No path from the output readies: a full FIFO blocks even if popping.
  assign in_ready = sel ? !full_a : !full_b;
  assign accept   = in_valid && in_ready;
  assign push_a   = accept && sel;
  assign push_b   = accept && !sel;

  demux1to2_fifo #(.N(N), .DEPTH(DEPTH)) u_fifo_a (
    .clk   (clk),
    .rst   (rst),
    .push  (push_a),
    .wdata (in_data),
    .pop   (a_ready),
    .full  (full_a),
    .valid (a_valid),
    .rdata (a_data)
  );

  demux1to2_fifo #(.N(N), .DEPTH(DEPTH)) u_fifo_b (
    .clk   (clk),
    .rst   (rst),
    .push  (push_b),
    .wdata (in_data),
    .pop   (b_ready),
    .full  (full_b),
    .valid (b_valid),
    .rdata (b_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_count <= '0;
      b_count <= '0;
    end else begin
      if (push_a) a_count <= a_count + 1'b1;
      if (push_b) b_count <= b_count + 1'b1;
    end
  end
endmodule

// File: tb/tb_demux1to2_stream.sv
// Randomized and directed bench for demux1to2_stream against a
// queue-based model; a CW=4 twin instance shares stimulus for wrap checks.

module tb_demux1to2_stream;
  localparam int N     = 4;
  localparam int DEPTH = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic         sel;
  logic [N-1:0] in_data;
  logic         a_valid;
  logic         a_ready;
  logic [N-1:0] a_data;
  logic         b_valid;
  logic         b_ready;
  logic [N-1:0] b_data;
  logic [15:0]  a_count;
  logic [15:0]  b_count;

  logic         t_in_ready;
  logic         t_a_valid;
  logic [N-1:0] t_a_data;
  logic         t_b_valid;
  logic [N-1:0] t_b_data;
  logic [3:0]   t_a_count;
  logic [3:0]   t_b_count;

  int n_chk  = 0;
  int n_fail = 0;

  logic [N-1:0] qa[$];
  logic [N-1:0] qb[$];
  int ca = 0;
  int cb = 0;

  logic         o_rdy;
  logic         o_av;
  logic [N-1:0] o_ad;
  logic         o_bv;
  logic [N-1:0] o_bd;

  always #5 clk = ~clk;

  demux1to2_stream #(.N(N), .DEPTH(DEPTH), .CW(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .sel      (sel),
    .in_data  (in_data),
    .a_valid  (a_valid),
    .a_ready  (a_ready),
    .a_data   (a_data),
    .b_valid  (b_valid),
    .b_ready  (b_ready),
    .b_data   (b_data),
    .a_count  (a_count),
    .b_count  (b_count)
  );

  demux1to2_stream #(.N(N), .DEPTH(DEPTH), .CW(4)) dut4 (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (t_in_ready),
    .sel      (sel),
    .in_data  (in_data),
    .a_valid  (t_a_valid),
    .a_ready  (a_ready),
    .a_data   (t_a_data),
    .b_valid  (t_b_valid),
    .b_ready  (b_ready),
    .b_data   (t_b_data),
    .a_count  (t_a_count),
    .b_count  (t_b_count)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // One cycle: drive, compare against the model, clock, advance model.
  task automatic step(input bit v, input bit s,
                      input logic [N-1:0] d,
                      input bit ar, input bit br);
    bit e_rdy, e_av, e_bv, do_a, do_b, pa, pb;
    logic [N-1:0] e_ad, e_bd;
    in_valid = v;
    sel      = s;
    in_data  = d;
    a_ready  = ar;
    b_ready  = br;
    #1;
    e_rdy = s ? (qa.size() < DEPTH) : (qb.size() < DEPTH);
    e_av  = qa.size() > 0;
    e_bv  = qb.size() > 0;
    e_ad  = e_av ? qa[0] : '0;
    e_bd  = e_bv ? qb[0] : '0;
    o_rdy = in_ready;
    o_av  = a_valid;
    o_ad  = a_data;
    o_bv  = b_valid;
    o_bd  = b_data;
    chk("in_ready", in_ready, e_rdy);
    chk("a_valid", a_valid, e_av);
    chk("a_data", a_data, e_ad);
    chk("b_valid", b_valid, e_bv);
    chk("b_data", b_data, e_bd);
    chk("a_count", a_count, ca % 65536);
    chk("b_count", b_count, cb % 65536);
    chk("a_count4", t_a_count, ca % 16);
    chk("b_count4", t_b_count, cb % 16);
    chk("in_ready4", t_in_ready, e_rdy);
    do_a = v && e_rdy && s;
    do_b = v && e_rdy && !s;
    pa   = e_av && ar;
    pb   = e_bv && br;
    @(posedge clk);
    if (pa) void'(qa.pop_front());
    if (pb) void'(qb.pop_front());
    if (do_a) begin qa.push_back(d); ca++; end
    if (do_b) begin qb.push_back(d); cb++; end
    @(negedge clk);
  endtask

  task automatic do_reset();
    #2 rst = 1'b1;
    #1;
    chk("rst_a_valid", a_valid, 0);
    chk("rst_b_valid", b_valid, 0);
    chk("rst_a_count", a_count, 0);
    chk("rst_b_count", b_count, 0);
    qa.delete();
    qb.delete();
    ca = 0;
    cb = 0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int base;
    rst      = 1'b1;
    in_valid = 1'b0;
    sel      = 1'b0;
    in_data  = '0;
    a_ready  = 1'b0;
    b_ready  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    step(0, 1, 0, 0, 0);

    // Reset mid-cycle with two beats held in out_a
    step(1, 1, 4'h9, 0, 0);
    step(1, 1, 4'hA, 0, 0);
    chk("pre_rst_a_valid", a_valid, 1);
    do_reset();
    step(0, 1, 0, 0, 0);
    chk("post_rst_rdy_a", o_rdy, 1);
    step(0, 0, 0, 0, 0);
    chk("post_rst_rdy_b", o_rdy, 1);

    // Basic steer
    step(1, 1, 4'h3, 1, 1);
    step(1, 0, 4'hC, 1, 1);
    chk("steer_a", {o_av, o_ad}, {1'b1, 4'h3});
    step(0, 0, 0, 1, 1);
    chk("steer_b", {o_bv, o_bd}, {1'b1, 4'hC});
    chk("steer_cnt", {a_count, b_count}, {16'd1, 16'd1});

    // Full / blocking
    do_reset();
    step(1, 1, 4'h1, 0, 1);
    step(1, 1, 4'h2, 0, 1);
    step(1, 1, 4'h7, 0, 1);
    chk("full_block", o_rdy, 0);
    step(1, 0, 4'h8, 0, 1);
    chk("other_ok", o_rdy, 1);
    step(0, 0, 0, 1, 1);
    chk("drain1", o_ad, 4'h1);
    step(0, 0, 0, 1, 1);
    chk("drain2", {o_av, o_ad}, {1'b1, 4'h2});
    step(0, 0, 0, 1, 1);
    chk("drained", o_av, 0);

    // Simultaneous push/pop at occupancy 1
    do_reset();
    step(1, 0, 4'h5, 1, 1);
    step(1, 0, 4'h6, 1, 1);
    chk("pp_old", {o_bv, o_bd, o_rdy}, {1'b1, 4'h5, 1'b1});
    step(0, 0, 0, 1, 1);
    chk("pp_new", {o_bv, o_bd}, {1'b1, 4'h6});
    step(0, 0, 0, 1, 1);
    chk("pp_empty", o_bv, 0);

    // Streaming 50 beats
    base = ca + cb;
    for (int i = 0; i < 50; i++) begin
      step(1, 1'($urandom), 4'($urandom), 1, 1);
      chk("stream_rdy", o_rdy, 1);
    end
    chk("stream_sum", 32'(a_count) + 32'(b_count), base + 50);

    // Counter wrap on the CW=4 twin
    do_reset();
    for (int i = 0; i < 17; i++) step(1, 1, 4'(i), 1, 1);
    step(0, 0, 0, 1, 1);
    chk("wrap4", t_a_count, 4'h1);
    chk("wrap16", a_count, 16'd17);

    // Random traffic with random back-pressure
    for (int i = 0; i < 400; i++)
      step(1'($urandom), 1'($urandom), 4'($urandom),
           ($urandom_range(0, 3) != 0), 1'($urandom));
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 1);
    chk("final_a_empty", a_valid, 0);
    chk("final_b_empty", b_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
    $finish;
  end
endmodule
